// File: rtl/writeback_unit.sv
// Writeback stage: a 2-entry result buffer feeding the register file write port,
// plus a per-register outstanding-write scoreboard that decode queries for hazards.
module writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rf_ready,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] query_addr_1,
  input  logic [ADDR_W-1:0] query_addr_2,
  output logic              hazard_1,
  output logic              hazard_2
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on valid, and a non-transferring offer may change freely.
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_dest [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];

  logic [1:0]        cnt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  logic accept;
  logic enq;
  logic retire;
  logic issue_inc;

  // Result buffer handshake and head presentation
  assign wb_ready       = (count < CNT_W'(DEPTH));
  assign accept         = wb_valid && wb_ready;
  assign enq            = accept && wb_reg_write && (wb_dest != '0);
  assign reg_write_en   = (count != '0);
  assign reg_write_dest = reg_write_en ? fifo_dest[rd_ptr] : '0;
  assign reg_write_data = reg_write_en ? fifo_data[rd_ptr] : '0;
  assign retire         = reg_write_en && rf_ready;

  // Scoreboard query ports
  assign issue_ready = !((issue_dest != '0) && (cnt[issue_dest] == 2'd3));
  assign issue_inc   = issue_valid && issue_ready && (issue_dest != '0);
  assign hazard_1    = (cnt[query_addr_1] != 2'd0);
  assign hazard_2    = (cnt[query_addr_2] != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      fifo_dest[wr_ptr] <= wb_dest;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_inc) begin
      inc_vec[issue_dest] = 1'b1;
    end
    if (retire) begin
      dec_vec[reg_write_dest] = 1'b1;
    end
  end

  // Same-edge issue and retire on one register cancel; a stray retire saturates at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= 2'd0;
      end
    end else begin
      cnt[0] <= 2'd0;
      for (int i = 1; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 2'd1;
        end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != 2'd0)) begin
          cnt[i] <= cnt[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-and-counter model of the unit.
module tb_writeback_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              rf_ready;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              issue_ready;
  logic [ADDR_W-1:0] query_addr_1;
  logic [ADDR_W-1:0] query_addr_2;
  logic              hazard_1;
  logic              hazard_2;

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_reg_write   (wb_reg_write),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .rf_ready       (rf_ready),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_ready    (issue_ready),
    .query_addr_1   (query_addr_1),
    .query_addr_2   (query_addr_2),
    .hazard_1       (hazard_1),
    .hazard_2       (hazard_2)
  );

  // Clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  // Model: in-flight results as {dest, data}, outstanding writes per register,
  // and issued-but-not-yet-offered writes (used only to keep stimulus legal).
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int cnt_m [NREG];
  int pend  [NREG];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin : model
    logic              do_ret;
    logic              do_acc;
    logic              do_iss;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W+DATA_W-1:0] head;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NREG; i++) begin
        cnt_m[i] = 0;
        pend[i]  = 0;
      end
      started = 1'b1;
    end else if (started) begin
      do_ret = (exp_q.size() != 0) && rf_ready;
      do_acc = wb_valid && (exp_q.size() < 2);
      do_iss = issue_valid && (issue_dest != 0) && (cnt_m[issue_dest] < 3);
      r = '0;
      if (do_ret) begin
        head = exp_q.pop_front();
        r = head[DATA_W +: ADDR_W];
      end
      if (do_acc && wb_reg_write && (wb_dest != 0)) begin
        exp_q.push_back({wb_dest, wb_data});
        if (pend[wb_dest] > 0) pend[wb_dest]--;
      end
      if (do_iss) pend[issue_dest]++;
      if (!(do_iss && do_ret && (issue_dest == r))) begin
        if (do_iss) cnt_m[issue_dest]++;
        if (do_ret) begin
          if (cnt_m[r] == 0) begin
            n_checks++;
            $display("FAIL protocol: retire to r%0d with outstanding 0, expected >=1", r);
          end else begin
            cnt_m[r]--;
          end
        end
      end
    end
  end

  // Compare process: outputs are combinational from state, checked mid-cycle.
  always @(negedge clk) begin : compare
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     exp_en;
    if (started) begin
      exp_en = (exp_q.size() != 0);
      head   = exp_en ? exp_q[0] : '0;
      check("wb_ready",       {31'd0, wb_ready},       {31'd0, exp_q.size() < 2});
      check("reg_write_en",   {31'd0, reg_write_en},   {31'd0, exp_en});
      check("reg_write_dest", {27'd0, reg_write_dest}, {27'd0, head[DATA_W +: ADDR_W]});
      check("reg_write_data", {16'd0, reg_write_data}, {16'd0, head[DATA_W-1:0]});
      check("issue_ready",    {31'd0, issue_ready},
            {31'd0, !((issue_dest != 0) && (cnt_m[issue_dest] == 3))});
      check("hazard_1",       {31'd0, hazard_1},       {31'd0, cnt_m[query_addr_1] != 0});
      check("hazard_2",       {31'd0, hazard_2},       {31'd0, cnt_m[query_addr_2] != 0});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst          = 1'b0;
    wb_valid     = 1'b0;
    wb_reg_write = 1'b0;
    wb_dest      = '0;
    wb_data      = '0;
    issue_valid  = 1'b0;
    issue_dest   = '0;
  endtask

  task automatic offer(input int d, input int v);
    wb_valid     = 1'b1;
    wb_reg_write = 1'b1;
    wb_dest      = ADDR_W'(d);
    wb_data      = DATA_W'(v);
  endtask

  task automatic issue(input int d);
    issue_valid = 1'b1;
    issue_dest  = ADDR_W'(d);
  endtask

  task automatic random_cycle();
    int cand[$];
    rst = ($urandom_range(0, 299) == 0);
    issue_valid = $urandom_range(0, 1) == 1;
    issue_dest  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31))
                                               : ADDR_W'($urandom_range(0, 6));
    for (int i = 1; i < NREG; i++) if (pend[i] > 0) cand.push_back(i);
    wb_valid = $urandom_range(0, 2) != 0;
    wb_data  = DATA_W'($urandom);
    if ((cand.size() != 0) && ($urandom_range(0, 3) != 0)) begin
      wb_reg_write = 1'b1;
      wb_dest      = ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
    end else if ($urandom_range(0, 1) == 1) begin
      wb_reg_write = 1'b1;
      wb_dest      = '0;
    end else begin
      wb_reg_write = 1'b0;
      wb_dest      = ADDR_W'($urandom_range(0, 31));
    end
    rf_ready     = $urandom_range(0, 3) != 0;
    query_addr_1 = ADDR_W'($urandom_range(0, 7));
    query_addr_2 = ADDR_W'($urandom_range(0, 7));
  endtask

  initial begin
    idle();
    rst          = 1'b1;
    rf_ready     = 1'b1;
    query_addr_1 = '0;
    query_addr_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    #1;
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    check("rst_en",       {31'd0, reg_write_en}, 32'd0);
    check("rst_issue_rdy", {31'd0, issue_ready}, 32'd1);

    // Single issue, write, retire on register 3
    query_addr_1 = 5'd3;
    issue(3);
    #1 check("s1_hazard_pre", {31'd0, hazard_1}, 32'd0);
    tick();
    idle();
    offer(3, 16'h00A5);
    #1 check("s1_hazard_issued", {31'd0, hazard_1}, 32'd1);
    check("s1_en_empty", {31'd0, reg_write_en}, 32'd0);
    tick();
    idle();
    #1 check("s1_en", {31'd0, reg_write_en}, 32'd1);
    check("s1_dest", {27'd0, reg_write_dest}, 32'd3);
    check("s1_data", {16'd0, reg_write_data}, 32'h00A5);
    check("s1_hazard_hold", {31'd0, hazard_1}, 32'd1);
    tick();
    #1 check("s1_en_after", {31'd0, reg_write_en}, 32'd0);
    check("s1_hazard_after", {31'd0, hazard_1}, 32'd0);

    // Back-pressure from the register file
    rf_ready = 1'b0;
    for (int r = 10; r <= 12; r++) begin
      issue(r);
      tick();
    end
    idle();
    offer(10, 1);
    #1 check("s2_rdy0", {31'd0, wb_ready}, 32'd1);
    tick();
    offer(11, 2);
    #1 check("s2_rdy1", {31'd0, wb_ready}, 32'd1);
    tick();
    offer(12, 3);
    #1 check("s2_full", {31'd0, wb_ready}, 32'd0);
    check("s2_head", {27'd0, reg_write_dest}, 32'd10);
    tick();
    rf_ready = 1'b1;
    #1 check("s2_full_hold", {31'd0, wb_ready}, 32'd0);
    tick();
    #1 check("s2_rdy_again", {31'd0, wb_ready}, 32'd1);
    check("s2_head2", {27'd0, reg_write_dest}, 32'd11);
    check("s2_data2", {16'd0, reg_write_data}, 32'd2);
    tick();
    idle();
    #1 check("s2_head3", {27'd0, reg_write_dest}, 32'd12);
    check("s2_data3", {16'd0, reg_write_data}, 32'd3);
    tick();
    #1 check("s2_drained", {31'd0, reg_write_en}, 32'd0);

    // Discarded results
    offer(0, 16'hFFFF);
    #1 check("s3_rdy_r0", {31'd0, wb_ready}, 32'd1);
    tick();
    offer(5, 16'h1234);
    wb_reg_write = 1'b0;
    query_addr_1 = 5'd5;
    #1 check("s3_rdy_nowr", {31'd0, wb_ready}, 32'd1);
    check("s3_en_r0", {31'd0, reg_write_en}, 32'd0);
    tick();
    idle();
    #1 check("s3_en_nowr", {31'd0, reg_write_en}, 32'd0);
    check("s3_hazard5", {31'd0, hazard_1}, 32'd0);

    // Counter saturation on register 7
    rf_ready = 1'b0;
    issue(7);
    for (int k = 0; k < 3; k++) begin
      #1 check("s4_rdy_fill", {31'd0, issue_ready}, 32'd1);
      tick();
    end
    #1 check("s4_rdy7_sat", {31'd0, issue_ready}, 32'd0);
    issue_dest = 5'd8;
    #1 check("s4_rdy8", {31'd0, issue_ready}, 32'd1);
    idle();
    issue_dest = 5'd7;
    offer(7, 16'h0077);
    tick();
    idle();
    issue_dest = 5'd7;
    rf_ready = 1'b1;
    #1 check("s4_rdy7_pre", {31'd0, issue_ready}, 32'd0);
    tick();
    #1 check("s4_rdy7_post", {31'd0, issue_ready}, 32'd1);

    // Same-edge issue and retire on register 9
    idle();
    rf_ready = 1'b0;
    issue(9);
    tick();
    idle();
    offer(9, 16'h0009);
    tick();
    idle();
    rf_ready = 1'b1;
    issue(9);
    query_addr_1 = 5'd9;
    #1 check("s5_head9", {27'd0, reg_write_dest}, 32'd9);
    check("s5_hazard_pre", {31'd0, hazard_1}, 32'd1);
    tick();
    idle();
    #1 check("s5_hazard_kept", {31'd0, hazard_1}, 32'd1);
    check("s5_en", {31'd0, reg_write_en}, 32'd0);

    // Reset with buffered results and outstanding writes
    rf_ready = 1'b0;
    issue(4);
    tick();
    tick();
    idle();
    offer(4, 16'h00AA);
    tick();
    offer(4, 16'h00BB);
    tick();
    idle();
    query_addr_1 = 5'd4;
    query_addr_2 = 5'd7;
    #1 check("s6_full", {31'd0, wb_ready}, 32'd0);
    check("s6_hazard4", {31'd0, hazard_1}, 32'd1);
    check("s6_hazard7", {31'd0, hazard_2}, 32'd1);
    rst = 1'b1;
    rf_ready = 1'b1;
    offer(4, 16'h00CC);
    issue(4);
    tick();
    idle();
    #1 check("s6_wb_ready", {31'd0, wb_ready}, 32'd1);
    check("s6_en", {31'd0, reg_write_en}, 32'd0);
    check("s6_dest", {27'd0, reg_write_dest}, 32'd0);
    check("s6_data", {16'd0, reg_write_data}, 32'd0);
    check("s6_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("s6_hazard1", {31'd0, hazard_1}, 32'd0);
    check("s6_hazard2", {31'd0, hazard_2}, 32'd0);
    tick();
    #1 check("s6_no_write", {31'd0, reg_write_en}, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      random_cycle();
      tick();
    end
    idle();
    rf_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
